spi_receiver: RTL and testbench

SPI_RECEIVER -- requirements
Module: spi_receiver

---
 rtl/spi_receiver.sv | 173 +++++++++++++++++
 tb/tb_spi_receiver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_receiver.sv
// SPI slave receiver: samples sdi on the selected sclk edge, assembles words.
// Optional macro SPI_RECEIVER_SYNC_EN adds a second synchronizer flop per input.
module spi_receiver #(
   parameter int bitcount      = 8,
   parameter int ss_polarity   = 0,
   parameter int sclk_polarity = 1,
   parameter int sclk_phase    = 1,
   parameter int msb_first     = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                ss,
   input  logic                sclk,
   input  logic                sdi,
   output logic [bitcount-1:0] data,
   output logic                valid,
   output logic                error,
   output logic                busy
);

`ifdef SPI_RECEIVER_SYNC_EN
   localparam int N = 2;
`else
   localparam int N = 1;
`endif

   localparam int   CW         = $clog2(bitcount + 1);
   localparam logic SS_ACT     = (ss_polarity != 0);
   localparam logic SCLK_IDLE  = (sclk_polarity != 0);
   localparam logic SAMPLE_LVL = (sclk_phase != 0) ? SCLK_IDLE : ~SCLK_IDLE;
   localparam logic [CW-1:0] LAST = CW'(bitcount - 1);

   typedef enum logic [1:0] {
      WAIT_RELEASE,
      IDLE,
      ACTIVE
   } state_t;

   state_t state_q, state_d;

   logic [N-1:0] ss_sync_q;
   logic [N-1:0] sclk_sync_q;
   logic [N-1:0] sdi_sync_q;
   logic         sclk_dly_q;

   logic s_ss;
   logic s_sclk;
   logic s_sdi;
   logic ss_act;
   logic sample;

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [bitcount-1:0] sh_q, sh_d;
   logic [bitcount-1:0] shifted;
   logic [bitcount-1:0] data_q, data_d;
   logic                valid_q, valid_d;
   logic                error_q, error_d;

   // Input stage: plain pipeline, not reset so a frame in flight stays visible
   if (N == 1) begin : g_sync1
      always_ff @(posedge clock) begin
         ss_sync_q   <= ss;
         sclk_sync_q <= sclk;
         sdi_sync_q  <= sdi;
      end
   end else begin : g_syncn
      always_ff @(posedge clock) begin
         ss_sync_q   <= {ss_sync_q[N-2:0], ss};
         sclk_sync_q <= {sclk_sync_q[N-2:0], sclk};
         sdi_sync_q  <= {sdi_sync_q[N-2:0], sdi};
      end
   end

   assign s_ss   = ss_sync_q[N-1];
   assign s_sclk = sclk_sync_q[N-1];
   assign s_sdi  = sdi_sync_q[N-1];

   // Delayed copy of synchronized sclk for edge detection
   always_ff @(posedge clock) begin
      sclk_dly_q <= s_sclk;
   end

   assign ss_act = (s_ss == SS_ACT);
   assign sample = (s_sclk != sclk_dly_q) && (s_sclk == SAMPLE_LVL);

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= WAIT_RELEASE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WAIT_RELEASE: if (!ss_act) state_d = IDLE;
         IDLE:         if (ss_act)  state_d = ACTIVE;
         ACTIVE:       if (!ss_act) state_d = IDLE;
         default:      state_d = WAIT_RELEASE;
      endcase
   end

   // New shift-register contents for one incoming bit
   always_comb begin
      shifted = '0;
      if (msb_first != 0) begin
         shifted = {sh_q[bitcount-2:0], s_sdi};
      end else begin
         shifted = {s_sdi, sh_q[bitcount-1:1]};
      end
   end

   // FSM output and datapath next-state logic; deassertion beats sampling
   always_comb begin
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      data_d  = data_q;
      valid_d = 1'b0;
      error_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ss_act) begin
               cnt_d = '0;
               sh_d  = '0;
            end
         end
         ACTIVE: begin
            if (!ss_act) begin
               error_d = (cnt_q != '0);
               cnt_d   = '0;
               sh_d    = '0;
            end else if (sample) begin
               sh_d = shifted;
               if (cnt_q == LAST) begin
                  data_d  = shifted;
                  valid_d = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         error_q <= error_d;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;
   assign error = error_q;
   assign busy  = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_receiver.sv
// Directed bench for spi_receiver: an MSB-first and an LSB-first instance
// share the same SPI pins; pulses and captured words are logged per instance.
module tb_spi_receiver;

   logic       clk;
   logic       rst;
   logic       ss;
   logic       sclk;
   logic       sdi;

   logic [7:0] data_m, data_l;
   logic       valid_m, valid_l;
   logic       error_m, error_l;
   logic       busy_m, busy_l;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] vq_m[$];
   logic [7:0] vq_l[$];
   int err_m  = 0;
   int err_l  = 0;
   int both   = 0;
   int bad_ch = 0;
   logic [7:0] prev_m = 8'h00;

   spi_receiver #(
      .bitcount(8), .ss_polarity(0), .sclk_polarity(1),
      .sclk_phase(1), .msb_first(1)
   ) u_msb (
      .clock(clk), .reset(rst), .ss(ss), .sclk(sclk), .sdi(sdi),
      .data(data_m), .valid(valid_m), .error(error_m), .busy(busy_m)
   );

   spi_receiver #(
      .bitcount(8), .ss_polarity(0), .sclk_polarity(1),
      .sclk_phase(1), .msb_first(0)
   ) u_lsb (
      .clock(clk), .reset(rst), .ss(ss), .sclk(sclk), .sdi(sdi),
      .data(data_l), .valid(valid_l), .error(error_l), .busy(busy_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid_m) vq_m.push_back(data_m);
      if (valid_l) vq_l.push_back(data_l);
      if (error_m) err_m++;
      if (error_l) err_l++;
      if ((valid_m && error_m) || (valid_l && error_l)) both++;
      if (!rst && !valid_m && data_m != prev_m) bad_ch++;
      prev_m = data_m;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_out(input logic b);
      sdi  = b;
      sclk = 1'b0;
      wclk(4);
      sclk = 1'b1;
      wclk(4);
   endtask

   task automatic bits_msb(input logic [7:0] w, input int n);
      for (int i = 7; i > 7 - n; i--) bit_out(w[i]);
   endtask

   task automatic frame_start();
      ss = 1'b0;
      wclk(4);
   endtask

   task automatic frame_end();
      wclk(2);
      ss = 1'b1;
      wclk(8);
   endtask

   int vm0, vl0, em0;
   logic [7:0] seq;

   initial begin
      rst  = 1'b1;
      ss   = 1'b1;
      sclk = 1'b1;
      sdi  = 1'b0;
      wclk(4);
      chk("rst_data", 32'(data_m), 32'h0);
      chk("rst_valid", 32'(valid_m), 32'h0);
      chk("rst_error", 32'(error_m), 32'h0);
      chk("rst_busy", 32'(busy_m), 32'h0);
      rst = 1'b0;
      wclk(4);
      chk("idle_busy", 32'(busy_m), 32'h0);

      // frame 1: 3b
      frame_start();
      chk("busy_in_frame", 32'(busy_m), 32'h1);
      bits_msb(8'h3b, 8);
      frame_end();
      chk("f1_nvalid", 32'(vq_m.size()), 32'd1);
      chk("f1_data", 32'(data_m), 32'h3b);
      chk("f1_lsb_data", 32'(data_l), 32'hdc);
      chk("f1_err", 32'(err_m), 32'd0);
      chk("between_busy", 32'(busy_m), 32'h0);

      // frame 2: 8e
      frame_start();
      bits_msb(8'h8e, 8);
      frame_end();
      chk("f2_nvalid", 32'(vq_m.size()), 32'd2);
      chk("f2_word", 32'(vq_m[1]), 32'h8e);
      chk("f2_lsb_data", 32'(data_l), 32'h71);

      // LSB-first sequence 1,1,0,1,1,1,0,0
      seq = 8'b1101_1100;
      frame_start();
      bits_msb(seq, 8);
      frame_end();
      chk("lsb_data", 32'(data_l), 32'h3b);
      chk("lsb_msb_data", 32'(data_m), 32'hdc);

      // ss pulse with no edges
      vm0 = vq_m.size();
      em0 = err_m;
      frame_start();
      frame_end();
      chk("empty_valid", 32'(vq_m.size()), 32'(vm0));
      chk("empty_err", 32'(err_m), 32'(em0));

      // partial frame of 5 edges
      vm0 = vq_m.size();
      em0 = err_m;
      frame_start();
      bits_msb(8'ha5, 5);
      frame_end();
      chk("part_err", 32'(err_m - em0), 32'd1);
      chk("part_valid", 32'(vq_m.size()), 32'(vm0));
      chk("part_data", 32'(data_m), 32'hdc);
      chk("part_lsb_err", 32'(err_l - em0), 32'd1);

      // 16 edges in one frame
      vm0 = vq_m.size();
      em0 = err_m;
      frame_start();
      bits_msb(8'h3b, 8);
      bits_msb(8'h8e, 8);
      frame_end();
      chk("b2b_nvalid", 32'(vq_m.size() - vm0), 32'd2);
      chk("b2b_w0", 32'(vq_m[vm0]), 32'h3b);
      chk("b2b_w1", 32'(vq_m[vm0+1]), 32'h8e);
      chk("b2b_err", 32'(err_m), 32'(em0));

      // reset after edge 3, released before edge 4
      frame_start();
      bits_msb(8'h3b, 3);
      rst = 1'b1;
      wclk(2);
      rst = 1'b0;
      vm0 = vq_m.size();
      vl0 = vq_l.size();
      em0 = err_m;
      wclk(1);
      for (int i = 4; i >= 0; i--) bit_out(seq[i]);
      frame_end();
      chk("rstmid_valid", 32'(vq_m.size()), 32'(vm0));
      chk("rstmid_lsb_valid", 32'(vq_l.size()), 32'(vl0));
      chk("rstmid_err", 32'(err_m), 32'(em0));
      chk("rstmid_data", 32'(data_m), 32'h0);
      frame_start();
      bits_msb(8'h8e, 8);
      frame_end();
      chk("after_rst_data", 32'(data_m), 32'h8e);
      chk("after_rst_nvalid", 32'(vq_m.size() - vm0), 32'd1);

      chk("valid_err_overlap", 32'(both), 32'd0);
      chk("data_change_wo_valid", 32'(bad_ch), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
